// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter and baud generator among
// N_REQ byte requesters; reprograms baud_select, settles, then runs tx_wr/tx_busy.
module uart_tx_scheduler #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned BUSY_TIMEOUT  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [3*N_REQ-1:0]   req_baud,
  output logic [N_REQ-1:0]     grant,
  output logic [2:0]           baud_select,
  output logic [7:0]           tx_data,
  output logic                 tx_wr,
  input  logic                 tx_busy,
  output logic                 sched_busy,
  output logic                 err_timeout
);

  localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SUM_W   = IDX_W + 1;
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > BUSY_TIMEOUT) ? SETTLE_CYCLES : BUSY_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [2:0]  BAUD_RST = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_START, S_WAIT_BUSY, S_WAIT_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [N_REQ-1:0]   r_grant, w_grant_nxt;
  logic [2:0]         r_baud, w_baud_nxt;
  logic [7:0]         r_data, w_data_nxt;
  logic               r_tx_wr, w_tx_wr_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_err, w_err_nxt;

  logic               w_found;
  logic [IDX_W-1:0]   w_winner;
  logic [7:0]         w_win_data;
  logic [2:0]         w_win_baud;
  logic [SUM_W-1:0]   w_sum;
  logic [IDX_W-1:0]   w_idx;
  logic               w_launch;
  logic               w_timeout;

  // Search upward from the pointer, wrapping, for the first pending requester.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_win_data = '0;
    w_win_baud = '0;
    w_sum      = '0;
    w_idx      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + SUM_W'(i);
      if (w_sum >= SUM_W'(N_REQ)) w_sum = w_sum - SUM_W'(N_REQ);
      w_idx = w_sum[IDX_W-1:0];
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        w_winner   = w_idx;
        w_win_data = req_data[8*w_idx +: 8];
        w_win_baud = req_baud[3*w_idx +: 3];
      end
    end
  end

  // Foreign transmitter activity holds off arbitration.
  assign w_launch  = (r_state == S_IDLE) && w_found && !tx_busy;
  assign w_timeout = (r_state == S_WAIT_BUSY) && !tx_busy &&
                     (r_cnt == CNT_W'(BUSY_TIMEOUT - 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_grant <= '0;
      r_baud  <= BAUD_RST;
      r_data  <= '0;
      r_tx_wr <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_baud  <= w_baud_nxt;
      r_data  <= w_data_nxt;
      r_tx_wr <= w_tx_wr_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (w_win_baud != r_baud) ? S_SETTLE : S_START;
        end
      end
      S_SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) w_state_nxt = S_START;
        else                                    w_cnt_nxt   = CNT_W'(r_cnt + 1'b1);
      end
      S_START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy)        w_state_nxt = S_WAIT_DONE;
        else if (w_timeout) w_state_nxt = S_IDLE;
        else                w_cnt_nxt   = CNT_W'(r_cnt + 1'b1);
      end
      S_WAIT_DONE: begin
        if (!tx_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs; the winner is captured only on launch.
  always_comb begin
    w_grant_nxt = '0;
    w_baud_nxt  = r_baud;
    w_data_nxt  = r_data;
    w_ptr_nxt   = r_ptr;
    w_tx_wr_nxt = (w_state_nxt == S_START);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_err_nxt   = w_timeout;
    if (w_launch) begin
      w_grant_nxt[w_winner] = 1'b1;
      w_baud_nxt = w_win_baud;
      w_data_nxt = w_win_data;
      w_ptr_nxt  = (w_winner == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(w_winner + 1'b1);
    end
  end

  assign grant       = r_grant;
  assign baud_select = r_baud;
  assign tx_data     = r_data;
  assign tx_wr       = r_tx_wr;
  assign sched_busy  = r_busy;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: grant scoreboard, transmitter model,
// directed latency, round-robin, timeout, foreign-busy and reset scenarios.
module tb_uart_tx_scheduler;

  localparam int unsigned N_REQ         = 4;
  localparam int unsigned SETTLE_CYCLES = 2;
  localparam int unsigned BUSY_TIMEOUT  = 8;
  localparam int          XM_BUSY_LEN   = 5;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [11:0] req_baud;
  logic [3:0]  grant;
  logic [2:0]  baud_select;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic        sched_busy;
  logic        err_timeout;

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] data;
    logic [2:0] baud;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_grants = 0;
  int n_txwr   = 0;
  int n_err    = 0;
  int last_grant_cyc = -1;
  int last_txwr_cyc  = -1;
  int last_err_cyc   = -1;
  int idle_run       = 0;
  logic gap_chk  = 1'b0;
  logic gap_seen = 1'b0;

  // Transmitter model: 0 = responsive, 1 = never busy, 2 = busy forced by the test
  int   xm_mode    = 0;
  logic force_busy = 1'b0;
  logic m_busy     = 1'b0;
  int   xm_cnt     = 0;

  assign tx_busy = (xm_mode == 2) ? force_busy : ((xm_mode == 1) ? 1'b0 : m_busy);

  uart_tx_scheduler #(
    .N_REQ(N_REQ), .SETTLE_CYCLES(SETTLE_CYCLES), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_baud(req_baud),
    .grant(grant), .baud_select(baud_select), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_busy(tx_busy), .sched_busy(sched_busy), .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Busy rises the cycle after tx_wr and stays high XM_BUSY_LEN cycles.
  initial forever begin
    @(posedge clk);
    #1;
    if (reset) begin
      xm_cnt = 0;
      m_busy = 1'b0;
    end else begin
      if (xm_cnt > 0) begin
        m_busy = 1'b1;
        xm_cnt--;
      end else begin
        m_busy = 1'b0;
      end
      if (tx_wr) xm_cnt = XM_BUSY_LEN;
    end
  end

  // Output monitor: pops the scoreboard on every grant and logs event cycles.
  initial forever begin
    @(posedge clk);
    #2;
    if (!gap_chk) gap_seen = 1'b0;
    if (!sched_busy) idle_run++;
    if (grant != 4'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_grant", 32'(grant), 32'd0);
      end else begin
        e = sb.pop_front();
        check("grant", 32'(grant), 32'(e.grant));
        check("tx_data", 32'(tx_data), 32'(e.data));
        check("baud_select", 32'(baud_select), 32'(e.baud));
      end
      if (gap_chk && gap_seen) check("rr_idle_gap", idle_run, 1);
      gap_seen       = gap_chk;
      idle_run       = 0;
      last_grant_cyc = cyc;
      n_grants++;
    end
    if (tx_wr) begin
      last_txwr_cyc = cyc;
      n_txwr++;
    end
    if (err_timeout) begin
      last_err_cyc = cyc;
      n_err++;
      check("err_sched_idle", 32'(sched_busy), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic set_lane(input int i, input logic [7:0] d, input logic [2:0] b);
    req_data[8*i +: 8] = d;
    req_baud[3*i +: 3] = b;
  endtask

  task automatic push(input logic [3:0] g, input logic [7:0] d, input logic [2:0] b);
    exp_t x;
    x.grant = g;
    x.data  = d;
    x.baud  = b;
    sb.push_back(x);
  endtask

  // which: 0 = grants, 1 = tx_wr pulses, 2 = timeouts
  task automatic wait_count(input string tag, input int which, input int target);
    int k;
    int v;
    k = 0;
    v = (which == 0) ? n_grants : ((which == 1) ? n_txwr : n_err);
    while (v < target && k < 200) begin
      @(negedge clk);
      k++;
      v = (which == 0) ? n_grants : ((which == 1) ? n_txwr : n_err);
    end
    check(tag, v, target);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (sched_busy !== 1'b0 && k < 200);
    check(tag, 32'(sched_busy), 32'd0);
  endtask

  int t;
  int f;
  int g0;
  int e0;
  int w0;

  initial begin
    reset    = 1'b1;
    req      = 4'b0;
    req_data = '0;
    req_baud = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tx_wr", 32'(tx_wr), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_baud", 32'(baud_select), 32'd3);
    check("rst_sched_busy", 32'(sched_busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single request, baud already matching: grant and tx_wr together.
    set_lane(0, 8'h55, 3'b011);
    req = 4'b0001;
    t = cyc;
    push(4'b0001, 8'h55, 3'b011);
    wait_count("t1_grant_seen", 0, 1);
    check("t1_grant_lat", last_grant_cyc, t + 1);
    check("t1_txwr_lat", last_txwr_cyc, t + 1);
    req = 4'b0;
    wait_idle("t1_idle");
    check("t1_baud_kept", 32'(baud_select), 32'd3);

    // Baud change inserts SETTLE_CYCLES before tx_wr.
    @(negedge clk);
    set_lane(1, 8'hA3, 3'b111);
    req = 4'b0010;
    t = cyc;
    push(4'b0010, 8'hA3, 3'b111);
    wait_count("t2_grant_seen", 0, 2);
    check("t2_grant_lat", last_grant_cyc, t + 1);
    req = 4'b0;
    wait_count("t2_txwr_seen", 1, 2);
    check("t2_txwr_lat", last_txwr_cyc, t + 1 + SETTLE_CYCLES);
    wait_idle("t2_idle");

    // Round-robin with all four held, pointer restarted by reset.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 8'(8'h10 + i), 3'b011);
    push(4'b0001, 8'h10, 3'b011);
    push(4'b0010, 8'h11, 3'b011);
    push(4'b0100, 8'h12, 3'b011);
    push(4'b1000, 8'h13, 3'b011);
    push(4'b0001, 8'h10, 3'b011);
    g0 = n_grants;
    gap_chk = 1'b1;
    req = 4'b1111;
    wait_count("t3_grants_seen", 0, g0 + 5);
    req = 4'b0;
    wait_idle("t3_idle");
    gap_chk = 1'b0;

    // Dead transmitter: timeout, byte dropped, next requester served.
    xm_mode = 1;
    @(negedge clk);
    set_lane(1, 8'h4B, 3'b011);
    set_lane(2, 8'h5C, 3'b011);
    push(4'b0010, 8'h4B, 3'b011);
    push(4'b0100, 8'h5C, 3'b011);
    g0 = n_grants;
    e0 = n_err;
    req = 4'b0110;
    wait_count("t4_grant1_seen", 0, g0 + 1);
    req = 4'b0100;
    wait_count("t4_err1_seen", 2, e0 + 1);
    check("t4_err_lat", last_err_cyc - last_txwr_cyc, BUSY_TIMEOUT);
    wait_count("t4_grant2_seen", 0, g0 + 2);
    check("t4_next_grant", last_grant_cyc, last_err_cyc + 1);
    req = 4'b0;
    wait_count("t4_err2_seen", 2, e0 + 2);
    wait_idle("t4_idle");

    // Foreign busy blocks arbitration; grant follows the falling edge.
    xm_mode    = 2;
    force_busy = 1'b1;
    @(negedge clk);
    set_lane(0, 8'h77, 3'b011);
    push(4'b0001, 8'h77, 3'b011);
    g0 = n_grants;
    req = 4'b0001;
    repeat (6) @(negedge clk);
    check("t5_blocked", n_grants, g0);
    force_busy = 1'b0;
    f = cyc;
    wait_count("t5_grant_seen", 0, g0 + 1);
    check("t5_grant_lat", last_grant_cyc, f + 1);
    req = 4'b0;
    xm_mode = 0;
    wait_idle("t5_idle");

    // Reset while the frame is in flight at baud 101.
    @(negedge clk);
    set_lane(2, 8'h3C, 3'b101);
    push(4'b0100, 8'h3C, 3'b101);
    g0 = n_grants;
    w0 = n_txwr;
    req = 4'b0100;
    wait_count("t6_grant_seen", 0, g0 + 1);
    req = 4'b0;
    wait_count("t6_txwr_seen", 1, w0 + 1);
    repeat (3) @(negedge clk);
    check("t6_mid_busy", 32'(sched_busy), 32'd1);
    check("t6_mid_baud", 32'(baud_select), 32'd5);
    check("t6_mid_txbusy", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rst_busy", 32'(sched_busy), 32'd0);
    check("t6_rst_baud", 32'(baud_select), 32'd3);
    check("t6_rst_txwr", 32'(tx_wr), 32'd0);
    check("t6_rst_grant", 32'(grant), 32'd0);
    w0 = n_txwr;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("t6_no_txwr", n_txwr, w0);
    set_lane(0, 8'h81, 3'b011);
    set_lane(3, 8'h93, 3'b011);
    push(4'b0001, 8'h81, 3'b011);
    push(4'b1000, 8'h93, 3'b011);
    g0 = n_grants;
    req = 4'b1001;
    wait_count("t6_grant_a_seen", 0, g0 + 1);
    req = 4'b1000;
    wait_count("t6_grant_b_seen", 0, g0 + 2);
    req = 4'b0;
    wait_idle("t6_idle");

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("err_total", n_err, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
